// File: rtl/seq_sched.sv
// seq_sched: round-robin scheduler that streams a granted LEN-bit word LSB-first into a shared Mealy detector and counts its hits.
// Optional `SEQ_SCHED_FIRST_HIT_EN adds first_pos_o, the index of the first hit (LEN if none).
module seq_sched #(
    parameter int LEN = 16,
    parameter int CW  = 7
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [1:0]      req_i,
    input  logic [LEN-1:0]  data0_i,
    input  logic [LEN-1:0]  data1_i,
    input  logic            det_outp_i,
    output logic [1:0]      gnt_o,
    output logic            busy_o,
    output logic            det_clr_o,
    output logic            det_inp_o,
    output logic            done_o,
`ifdef SEQ_SCHED_FIRST_HIT_EN
    output logic [CW-1:0]   first_pos_o,
`endif
    output logic [CW-1:0]   count_o
);

    typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

    localparam logic [CW-1:0] LAST_K = CW'(LEN - 1);
    localparam logic [CW-1:0] NO_HIT = CW'(LEN);
    localparam logic [CW-1:0] ONE    = CW'(1);

    state_t         state_q;
    logic [LEN-1:0] sh_q;
    logic [CW-1:0]  kcnt_q;
    logic [CW-1:0]  match_q;
    logic [CW-1:0]  count_q;
    logic [1:0]     gnt_q;
    logic           busy_q;
    logic           det_clr_q;
    logic           done_q;
    logic           last_q;
    logic           win_d;
    logic [CW-1:0]  match_d;
`ifdef SEQ_SCHED_FIRST_HIT_EN
    logic [CW-1:0]  first_q;
    logic [CW-1:0]  first_pos_q;
    logic [CW-1:0]  first_d;
`endif

    // win_d = 1 selects requester 1; ties go to whoever was not served last
    always_comb begin
        win_d = 1'b0;
        case (req_i)
            2'b10:   win_d = 1'b1;
            2'b11:   win_d = ~last_q;
            default: win_d = 1'b0;
        endcase
        match_d = det_outp_i ? (match_q + ONE) : match_q;
`ifdef SEQ_SCHED_FIRST_HIT_EN
        first_d = (det_outp_i && (first_q == NO_HIT)) ? kcnt_q : first_q;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            kcnt_q      <= '0;
            match_q     <= '0;
            count_q     <= '0;
            gnt_q       <= 2'b00;
            busy_q      <= 1'b0;
            det_clr_q   <= 1'b0;
            done_q      <= 1'b0;
            last_q      <= 1'b1;
`ifdef SEQ_SCHED_FIRST_HIT_EN
            first_q     <= '0;
            first_pos_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i != 2'b00) begin
                        state_q   <= CLR;
                        sh_q      <= win_d ? data1_i : data0_i;
                        gnt_q     <= win_d ? 2'b10 : 2'b01;
                        match_q   <= '0;
                        kcnt_q    <= '0;
                        busy_q    <= 1'b1;
                        det_clr_q <= 1'b1;
`ifdef SEQ_SCHED_FIRST_HIT_EN
                        first_q   <= NO_HIT;
`endif
                    end
                end
                CLR: begin
                    state_q   <= SHIFT;
                    det_clr_q <= 1'b0;
                end
                SHIFT: begin
                    match_q <= match_d;
                    sh_q    <= sh_q >> 1;
`ifdef SEQ_SCHED_FIRST_HIT_EN
                    first_q <= first_d;
`endif
                    // the last bit's hit is folded in directly so count is valid with done
                    if (kcnt_q == LAST_K) begin
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        count_q     <= match_d;
`ifdef SEQ_SCHED_FIRST_HIT_EN
                        first_pos_q <= first_d;
`endif
                    end else begin
                        kcnt_q <= kcnt_q + ONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    gnt_q   <= 2'b00;
                    last_q  <= gnt_q[1];
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign det_inp_o   = (state_q == SHIFT) & sh_q[0];
    assign gnt_o       = gnt_q;
    assign busy_o      = busy_q;
    assign det_clr_o   = det_clr_q;
    assign done_o      = done_q;
    assign count_o     = count_q;
`ifdef SEQ_SCHED_FIRST_HIT_EN
    assign first_pos_o = first_pos_q;
`endif

endmodule
